// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with relative/absolute branching
// and a hardware return-address stack for CALL/RET.
module pc_sequencer #(
  parameter int unsigned PC_W        = 6,
  parameter int unsigned A_W         = 4,
  parameter int unsigned OFF_W       = 4,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             clk_main,
  input  logic             reset_n,
  input  logic [2:0]       PS,
  input  logic [A_W-1:0]   A,
  input  logic [OFF_W-1:0] offset,
  input  logic             cond,
  input  logic             stall,
  output logic [PC_W-1:0]  PC,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    MODE_HOLD   = 3'b000,
    MODE_INC    = 3'b001,
    MODE_BRANCH = 3'b010,
    MODE_ADDA   = 3'b011,
    MODE_BCOND  = 3'b100,
    MODE_JUMP   = 3'b101,
    MODE_CALL   = 3'b110,
    MODE_RET    = 3'b111
  } mode_e;

  mode_e            mode;
  logic [PC_W-1:0]  a_ext;
  logic [PC_W-1:0]  off_ext;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  pc_br;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             err_q, err_d;
  logic             full, empty;
  logic             push_en;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] pop_idx;
  logic [PC_W-1:0]  stack_q [STACK_DEPTH];

  // Operand A: zero-extend, or keep the low PC_W bits when wider than the PC.
  if (A_W >= PC_W) begin : g_a_trunc
    always_comb a_ext = A[PC_W-1:0];
  end else begin : g_a_zext
    always_comb a_ext = {{(PC_W-A_W){1'b0}}, A};
  end

  // Offset: sign-extend, or keep the low PC_W bits when wider than the PC.
  if (OFF_W >= PC_W) begin : g_off_trunc
    always_comb off_ext = offset[PC_W-1:0];
  end else begin : g_off_sext
    always_comb off_ext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
  end

  // Decode mode and stack status from registered state.
  always_comb begin
    mode     = mode_e'(PS);
    full     = (sp_q == SP_W'(STACK_DEPTH));
    empty    = (sp_q == '0);
    pc_inc   = pc_q + PC_W'(1);
    pc_br    = pc_q + off_ext + PC_W'(1);
    push_idx = IDX_W'(sp_q);
    pop_idx  = IDX_W'(sp_q - SP_W'(1));
  end

  // Next-state selection; stall overrides every mode and blocks the push.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (!stall) begin
      unique case (mode)
        MODE_HOLD:   pc_d = pc_q;
        MODE_INC:    pc_d = pc_inc;
        MODE_BRANCH: pc_d = pc_br;
        MODE_ADDA:   pc_d = pc_q + a_ext;
        MODE_BCOND:  pc_d = cond ? pc_br : pc_inc;
        MODE_JUMP:   pc_d = a_ext;
        MODE_CALL: begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
            pc_d    = pc_br;
          end
        end
        MODE_RET: begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            sp_d = sp_q - SP_W'(1);
            pc_d = stack_q[pop_idx];
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  // Control state: PC, stack pointer and sticky error flag.
  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Return-address storage; contents are only meaningful below sp, so no reset.
  always_ff @(posedge clk_main) begin
    if (push_en) stack_q[push_idx] <= pc_inc;
  end

  assign PC          = pc_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;

endmodule
